// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding a UART transmitter: queues host bytes and issues them one
// at a time as single-cycle start pulses, pacing on the transmitter's idle flag.
module uart_tx_fifo_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_SysClock,
    input  logic                  i_ResetN,
    input  logic                  i_WrEn,
    input  logic [7:0]            i_WrData,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Overflow,
    input  logic                  i_TxDone,
    output logic                  o_TxValid,
    output logic [7:0]            o_TxByte,
    output logic                  o_Idle
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_WAIT
    } state_t;

    state_t                state;
    logic                  busy_timer;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_next;
    logic [7:0]            mem [DEPTH];
    logic                  pop;
    logic                  push;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign pop  = (state == S_IDLE) && !o_Empty && i_TxDone;
    assign push = i_WrEn && (!o_Full || pop);

    assign o_Idle = o_Empty && (state == S_IDLE) && i_TxDone;

    // NOTE: every path of a combinational block must assign its outputs, so the
    // default comes first; otherwise the tool infers a latch to hold the old value.
    always_comb begin
        count_next = o_Count;
        if (push && !pop) begin
            count_next = o_Count + 1'b1;
        end else if (pop && !push) begin
            count_next = o_Count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge i_SysClock) begin
        if (push) begin
            mem[wr_ptr] <= i_WrData;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order or block order.
    always_ff @(posedge i_SysClock) begin
        if (!i_ResetN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_Count    <= count_next;
            o_Full     <= (count_next == FULL_COUNT);
            o_Empty    <= (count_next == '0);
            o_Overflow <= i_WrEn && o_Full && !pop;
        end
    end

    always_ff @(posedge i_SysClock) begin
        if (!i_ResetN) begin
            state      <= S_IDLE;
            o_TxValid  <= 1'b0;
            o_TxByte   <= 8'h00;
            busy_timer <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_TxByte  <= mem[rd_ptr];
                        o_TxValid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    o_TxValid  <= 1'b0;
                    busy_timer <= 1'b0;
                    state      <= S_BUSY;
                end
                S_BUSY: begin
                    // A start the transmitter never acknowledged is dropped, not replayed.
                    if (!i_TxDone) begin
                        state <= S_WAIT;
                    end else if (busy_timer) begin
                        state <= S_IDLE;
                    end else begin
                        busy_timer <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_TxDone) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for uart_tx_fifo_feeder: transmitter model, byte scoreboard, a
// table-driven fill/overflow sweep and hand-written multi-cycle sequences.
module tb_uart_tx_fifo_feeder;

    localparam int DL2 = 4;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
        logic        done;
        logic        prev;
        int unsigned rise;
    } pulse_t;

    typedef struct {
        logic         wr_en;
        logic [7:0]   data;
        logic [DL2:0] count;
        logic         full;
        logic         empty;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [7:0]   wr_data;
    logic         full;
    logic         empty;
    logic [DL2:0] count;
    logic         overflow;
    logic         tx_done_in;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         idle;

    logic        tx_idle;
    logic        hold_busy = 1'b0;
    logic        ignore_start = 1'b0;
    int          frame_len = 4;
    int unsigned cyc = 0;
    int unsigned rise_cyc;
    int unsigned ovf_cnt;
    int          checks = 0;
    int          errors = 0;

    logic [7:0] exp_q[$];
    pulse_t     seen_q[$];
    vec_t       vecs[18];

    assign tx_done_in = tx_idle && !hold_busy;

    uart_tx_fifo_feeder #(.DEPTH_LOG2(DL2)) dut (
        .i_SysClock (clk),
        .i_ResetN   (rst_n),
        .i_WrEn     (wr_en),
        .i_WrData   (wr_data),
        .o_Full     (full),
        .o_Empty    (empty),
        .o_Count    (count),
        .o_Overflow (overflow),
        .i_TxDone   (tx_done_in),
        .o_TxValid  (tx_valid),
        .o_TxByte   (tx_byte),
        .o_Idle     (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: records every start pulse, then stays busy frame_len cycles.
    initial begin : tx_model
        int busy_left;
        pulse_t rec;
        tx_idle   = 1'b1;
        busy_left = 0;
        rise_cyc  = 0;
        ovf_cnt   = 0;
        rec.prev  = 1'b0;
        forever begin
            logic prev_valid;
            prev_valid = rec.prev;
            @(negedge clk);
            if (overflow) ovf_cnt++;
            if (tx_valid) begin
                rec.data = tx_byte;
                rec.cyc  = cyc;
                rec.done = tx_done_in;
                rec.prev = prev_valid;
                rec.rise = rise_cyc;
                seen_q.push_back(rec);
                if (!ignore_start && busy_left == 0) begin
                    tx_idle   = 1'b0;
                    busy_left = frame_len;
                end
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_idle  = 1'b1;
                    rise_cyc = cyc;
                end
            end
            rec.prev = tx_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic expect_sent);
        tick();
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_sent) exp_q.push_back(b);
    endtask

    task automatic wait_pulses(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && seen_q.size() < n; i++) tick();
        check("pulse_count", seen_q.size(), n);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && !idle; i++) tick();
        check("o_Idle", idle, 1);
    endtask

    task automatic check_drain(input int n, input logic check_gaps);
        int idx;
        wait_pulses(n, n * (frame_len + 10) + 40);
        idx = 0;
        while (seen_q.size() > 0) begin
            pulse_t r;
            logic [8:0] e;
            r = seen_q.pop_front();
            e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check("tx_byte_order", {1'b0, r.data}, e);
            check("done_at_valid", r.done, 1);
            check("no_double_valid", r.prev, 0);
            if (check_gaps && idx > 0) check("frame_gap", r.cyc - r.rise, 2);
            idx++;
        end
        check("exp_left", exp_q.size(), 0);
    endtask

    initial begin : main
        int unsigned ovf0;
        pulse_t r1, r2;

        // Test 1: reset held with a push request active
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_count", count, 0);
            check("rst_empty", empty, 1);
            check("rst_full", full, 0);
            check("rst_valid", tx_valid, 0);
            check("rst_byte", tx_byte, 8'h00);
            check("rst_ovf", overflow, 0);
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        tick();
        check("post_rst_count", count, 0);
        check("post_rst_idle", idle, 1);

        // Test 2: single byte, latency and one pulse
        push_byte(8'hA5, 1'b1);
        tick();
        wr_en = 1'b0;
        check("lat_count1", count, 1);
        check("lat_valid0", tx_valid, 0);
        tick();
        check("lat_valid1", tx_valid, 1);
        check("lat_byte", tx_byte, 8'hA5);
        check("lat_count0", count, 0);
        check_drain(1, 1'b0);
        wait_idle(40);
        check("single_pulse", seen_q.size(), 0);
        check("byte_held", tx_byte, 8'hA5);

        // Test 3: 16-byte burst while the transmitter is held busy, then drain
        frame_len = 6;
        tick();
        hold_busy = 1'b1;
        ovf0 = ovf_cnt;
        for (int k = 1; k <= 16; k++) push_byte(k[7:0], 1'b1);
        tick();
        wr_en = 1'b0;
        check("burst_full", full, 1);
        check("burst_count", count, 16);
        check("burst_no_ovf", ovf_cnt - ovf0, 0);
        hold_busy = 1'b0;
        check_drain(16, 1'b1);
        wait_idle(40);

        // Test 4: 17 pushes against a busy transmitter, table-driven
        for (int k = 0; k < 17; k++) begin
            vecs[k].wr_en = 1'b1;
            vecs[k].data  = (k == 16) ? 8'hEE : 8'h40 + k[7:0];
            vecs[k].count = (k + 1 > 16) ? 5'd16 : 5'(k + 1);
            vecs[k].full  = (k >= 15);
            vecs[k].empty = 1'b0;
            vecs[k].ovf   = (k == 16);
        end
        vecs[17] = '{wr_en: 1'b0, data: 8'h00, count: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b0};
        tick();
        hold_busy = 1'b1;
        for (int i = 0; i <= 18; i++) begin
            tick();
            if (i > 0) begin
                check("tbl_count", count, vecs[i-1].count);
                check("tbl_full", full, vecs[i-1].full);
                check("tbl_empty", empty, vecs[i-1].empty);
                check("tbl_ovf", overflow, vecs[i-1].ovf);
                check("tbl_valid", tx_valid, 0);
            end
            if (i < 18) begin
                wr_en   = vecs[i].wr_en;
                wr_data = vecs[i].data;
                if (vecs[i].wr_en && i < 16) exp_q.push_back(vecs[i].data);
            end else begin
                wr_en = 1'b0;
            end
        end

        // Test 5: push on the same cycle as the pop from a full FIFO
        wr_en     = 1'b1;
        wr_data   = 8'h77;
        hold_busy = 1'b0;
        exp_q.push_back(8'h77);
        tick();
        wr_en = 1'b0;
        check("pp_count", count, 16);
        check("pp_full", full, 1);
        check("pp_ovf", overflow, 0);
        check("pp_valid", tx_valid, 1);
        check_drain(17, 1'b1);
        wait_idle(40);
        check("no_extra_pulse", seen_q.size(), 0);

        // Lost start: transmitter never drops done, FSM times out after 2 cycles
        ignore_start = 1'b1;
        push_byte(8'hB1, 1'b0);
        push_byte(8'hB2, 1'b0);
        tick();
        wr_en = 1'b0;
        wait_pulses(2, 40);
        if (seen_q.size() >= 2) begin
            r1 = seen_q.pop_front();
            r2 = seen_q.pop_front();
            check("to_byte1", r1.data, 8'hB1);
            check("to_byte2", r2.data, 8'hB2);
            check("to_spacing", r2.cyc - r1.cyc, 4);
        end
        wait_idle(40);
        ignore_start = 1'b0;
        seen_q.delete();

        // Test 6: reset while the FSM waits on a frame with 5 bytes queued
        frame_len = 20;
        for (int k = 0; k < 6; k++) push_byte(8'hC0 + k[7:0], 1'b1);
        tick();
        wr_en = 1'b0;
        check("pre_rst_count", count, 5);
        check("pre_rst_idle", idle, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("mid_rst_empty", empty, 1);
        check("mid_rst_valid", tx_valid, 0);
        tick();
        check("after_rst_empty", empty, 1);
        check("after_rst_count", count, 0);
        wait_pulses(1, 10);
        if (seen_q.size() > 0) begin
            r1 = seen_q.pop_front();
            check("rst_first_byte", r1.data, 8'hC0);
        end
        exp_q.delete();
        for (int i = 0; i < 30; i++) tick();
        check("no_valid_after_rst", seen_q.size(), 0);
        check("rst_idle", idle, 1);
        frame_len = 4;
        push_byte(8'h3C, 1'b1);
        tick();
        wr_en = 1'b0;
        check_drain(1, 1'b0);
        wait_idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
